// File: rtl/race_pkg.sv
// Shared definitions for the race game: screen geometry, palette,
// coordinate widths and the car datapath state encoding.
package race_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  // Raster counter width: rectangles up to 16x16.
  localparam int unsigned RC_W     = 4;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_RED   = 3'b100;
  localparam logic [2:0] COL_WHITE = 3'b111;
  localparam logic [2:0] COL_GREEN = 3'b010;

  typedef enum logic [2:0] {
    DP_IDLE,
    DP_DRAW,
    DP_CLEAR,
    DP_DONE_D,
    DP_DONE_C
  } dp_state_e;

endpackage

// File: rtl/rect_raster.sv
// Column/row scan counter over a RECT_W x RECT_H rectangle, row-major.
module rect_raster
  import race_pkg::*;
#(
  parameter int unsigned RECT_W = 8,
  parameter int unsigned RECT_H = 12
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clr,
  input  logic            step,
  output logic [RC_W-1:0] col,
  output logic [RC_W-1:0] row,
  output logic            start,
  output logic            last
);

  localparam logic [RC_W-1:0] COL_LAST = RC_W'(RECT_W - 1);
  localparam logic [RC_W-1:0] ROW_LAST = RC_W'(RECT_H - 1);

  logic [RC_W-1:0] col_q, col_d;
  logic [RC_W-1:0] row_q, row_d;

  // Next counter value: clear wins, otherwise advance and wrap to (0,0) after the last pixel.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (step) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RC_W'(1);
      end else begin
        col_d = col_q + RC_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col   = col_q;
  assign row   = row_q;
  assign start = (col_q == '0) && (row_q == '0);
  assign last  = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: rtl/car_draw_datapath.sv
// Car position register, move/clamp logic and draw/clear rasteriser feeding the VGA adapter.
module car_draw_datapath
  import race_pkg::*;
#(
  parameter int unsigned CAR_W         = 8,
  parameter int unsigned CAR_H         = 12,
  parameter int unsigned START_X       = 76,
  parameter int unsigned START_Y       = 100,
  parameter int unsigned STEP_X        = 4,
  parameter int unsigned STEP_Y        = 1,
  parameter int unsigned LANE_LEFT     = 40,
  parameter int unsigned LANE_RIGHT    = 119,
  parameter logic [2:0]  CAR_COLOUR    = COL_RED,
  parameter logic [2:0]  WINDOW_COLOUR = COL_WHITE,
  parameter logic [2:0]  BG_COLOUR     = COL_BLACK
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           draw_car,
  input  logic           clear,
  input  logic           move_straight,
  input  logic           move_left,
  input  logic           move_right,
  input  logic           reset_pos,
  output logic           done_car,
  output logic           done_clear,
  output logic [X_W-1:0] car_x,
  output logic [Y_W-1:0] car_y,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [2:0]     vga_colour,
  output logic           vga_plot
);

  localparam int unsigned X_MAX = LANE_RIGHT - CAR_W + 1;

  dp_state_e       state_q, state_d;
  logic [X_W-1:0]  car_x_q, car_x_d;
  logic [Y_W-1:0]  car_y_q, car_y_d;
  logic [X_W-1:0]  vga_x_q, vga_x_d;
  logic [Y_W-1:0]  vga_y_q, vga_y_d;
  logic [2:0]      colour_q, colour_d;
  logic            plot_q, plot_d;
  logic            done_car_q, done_car_d;
  logic            done_clear_q, done_clear_d;

  logic [RC_W-1:0] col, row;
  logic            r_start, r_last, r_clr, r_step;
  logic            emit, emit_bg, window;
  logic [8:0]      x_ext, x_sum;

  rect_raster #(
    .RECT_W (CAR_W),
    .RECT_H (CAR_H)
  ) u_raster (
    .clock (clock),
    .reset (reset),
    .clr   (r_clr),
    .step  (r_step),
    .col   (col),
    .row   (row),
    .start (r_start),
    .last  (r_last)
  );

  assign window = ((row == RC_W'(2)) || (row == RC_W'(3))) &&
                  (col >= RC_W'(1)) && (col <= RC_W'(CAR_W - 2));

  // Pixel (0,0) is launched from IDLE on the request cycle so the first plot lands one cycle later.
  always_comb begin
    state_d      = state_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    colour_d     = colour_q;
    plot_d       = 1'b0;
    done_car_d   = 1'b0;
    done_clear_d = 1'b0;
    r_clr        = 1'b0;
    r_step       = 1'b0;
    emit         = 1'b0;
    emit_bg      = 1'b0;
    unique case (state_q)
      DP_IDLE: begin
        if (clear && r_start) begin
          state_d = DP_CLEAR;
          emit    = 1'b1;
          emit_bg = 1'b1;
        end else if (draw_car && r_start) begin
          state_d = DP_DRAW;
          emit    = 1'b1;
        end else begin
          r_clr = 1'b1;
        end
      end
      DP_DRAW: begin
        emit = 1'b1;
        if (r_last) state_d = DP_DONE_D;
      end
      DP_CLEAR: begin
        emit    = 1'b1;
        emit_bg = 1'b1;
        if (r_last) state_d = DP_DONE_C;
      end
      DP_DONE_D: begin
        if (draw_car) done_car_d = 1'b1;
        else          state_d    = DP_IDLE;
      end
      DP_DONE_C: begin
        if (clear) done_clear_d = 1'b1;
        else       state_d      = DP_IDLE;
      end
      default: state_d = DP_IDLE;
    endcase
    if (emit) begin
      r_step   = 1'b1;
      plot_d   = 1'b1;
      vga_x_d  = car_x_q + X_W'(col);
      vga_y_d  = car_y_q + Y_W'(row);
      colour_d = emit_bg ? BG_COLOUR : (window ? WINDOW_COLOUR : CAR_COLOUR);
    end
  end

  // Position update with lane/top clamping; frozen from the raster launch cycle until back in IDLE.
  always_comb begin
    car_x_d = car_x_q;
    car_y_d = car_y_q;
    x_ext   = {1'b0, car_x_q};
    x_sum   = x_ext + 9'(STEP_X);
    if ((state_q == DP_IDLE) && !clear && !draw_car) begin
      if (reset_pos) begin
        car_x_d = X_W'(START_X);
        car_y_d = Y_W'(START_Y);
      end else if (move_straight) begin
        car_y_d = (car_y_q < Y_W'(STEP_Y)) ? '0 : car_y_q - Y_W'(STEP_Y);
      end else if (move_left) begin
        car_x_d = (x_ext < 9'(STEP_X + LANE_LEFT)) ? X_W'(LANE_LEFT) : X_W'(x_ext - 9'(STEP_X));
      end else if (move_right) begin
        car_x_d = (x_sum > 9'(X_MAX)) ? X_W'(X_MAX) : x_sum[X_W-1:0];
      end
    end
  end

  // State, position and registered VGA/done outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= DP_IDLE;
      car_x_q      <= X_W'(START_X);
      car_y_q      <= Y_W'(START_Y);
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      colour_q     <= '0;
      plot_q       <= 1'b0;
      done_car_q   <= 1'b0;
      done_clear_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      car_x_q      <= car_x_d;
      car_y_q      <= car_y_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      colour_q     <= colour_d;
      plot_q       <= plot_d;
      done_car_q   <= done_car_d;
      done_clear_q <= done_clear_d;
    end
  end

  assign car_x      = car_x_q;
  assign car_y      = car_y_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = colour_q;
  assign vga_plot   = plot_q;
  assign done_car   = done_car_q;
  assign done_clear = done_clear_q;

endmodule

// File: tb/tb_car_draw_datapath.sv
// Self-checking bench for car_draw_datapath against a behavioural position/raster model.
module tb_car_draw_datapath;

  localparam int W = 8, H = 12, SX = 76, SY = 100;
  localparam int XMIN = 40, XMAX = 112;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       draw_car = 1'b0, clear = 1'b0;
  logic       move_straight = 1'b0, move_left = 1'b0, move_right = 1'b0, reset_pos = 1'b0;
  logic       done_car, done_clear, vga_plot;
  logic [7:0] car_x, vga_x;
  logic [6:0] car_y, vga_y;
  logic [2:0] vga_colour;

  int vectors = 0;
  int errors  = 0;
  int mx = SX, my = SY;

  car_draw_datapath dut (
    .clock(clock), .reset(reset), .draw_car(draw_car), .clear(clear),
    .move_straight(move_straight), .move_left(move_left), .move_right(move_right),
    .reset_pos(reset_pos), .done_car(done_car), .done_clear(done_clear),
    .car_x(car_x), .car_y(car_y), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int exp_colour(input bit is_clear, input int c, input int r);
    if (is_clear) return 0;
    if ((r == 2 || r == 3) && c >= 1 && c <= W - 2) return 7;
    return 4;
  endfunction

  // Apply one move pulse (inputs are a 4-bit set) and advance the model by the priority rule.
  task automatic pulse(input bit rp, input bit st, input bit l, input bit r);
    reset_pos = rp; move_straight = st; move_left = l; move_right = r;
    tick();
    reset_pos = 0; move_straight = 0; move_left = 0; move_right = 0;
    if (rp)      begin mx = SX; my = SY; end
    else if (st) my = (my - 1 < 0) ? 0 : my - 1;
    else if (l)  mx = (mx - 4 < XMIN) ? XMIN : mx - 4;
    else if (r)  mx = (mx + 4 > XMAX) ? XMAX : mx + 4;
    vectors++;
    if (car_x !== 8'(mx) || car_y !== 7'(my)) begin
      errors++;
      $display("FAIL move: pos=(%0d,%0d) expected (%0d,%0d)", car_x, car_y, mx, my);
    end
  endtask

  // Request must already be raised; checks every plot, then done handshake.
  task automatic check_raster(input bit is_clear, input int move_at, input int stop_at);
    int c, r;
    for (int i = 0; i < W * H; i++) begin
      if (i == stop_at) return;
      if (i == move_at) move_left = 1;
      tick();
      move_left = 0;
      c = i % W; r = i / W;
      vectors++;
      if (vga_plot !== 1'b1 || vga_x !== 8'(mx + c) || vga_y !== 7'(my + r) ||
          vga_colour !== 3'(exp_colour(is_clear, c, r))) begin
        errors++;
        $display("FAIL pixel %0d: plot=%b xy=(%0d,%0d) col=%0d expected plot=1 xy=(%0d,%0d) col=%0d",
                 i, vga_plot, vga_x, vga_y, vga_colour, mx + c, my + r, exp_colour(is_clear, c, r));
      end
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (vga_plot !== 1'b0 || done_car !== !is_clear || done_clear !== is_clear) begin
        errors++;
        $display("FAIL done hold %0d: plot=%b done_car=%b done_clear=%b expected 0/%b/%b",
                 k, vga_plot, done_car, done_clear, !is_clear, is_clear);
      end
    end
    draw_car = 0; clear = 0;
    tick();
    vectors++;
    if (done_car !== 1'b0 || done_clear !== 1'b0 || vga_plot !== 1'b0) begin
      errors++;
      $display("FAIL done release: done_car=%b done_clear=%b plot=%b expected 0/0/0",
               done_car, done_clear, vga_plot);
    end
    vectors++;
    if (car_x !== 8'(mx) || car_y !== 7'(my)) begin
      errors++;
      $display("FAIL pos after raster: (%0d,%0d) expected (%0d,%0d)", car_x, car_y, mx, my);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    tick(); tick();
    reset = 0;
    mx = SX; my = SY;
    vectors++;
    if (car_x !== 8'(SX) || car_y !== 7'(SY) || vga_x !== 0 || vga_y !== 0 ||
        vga_colour !== 0 || vga_plot !== 0 || done_car !== 0 || done_clear !== 0) begin
      errors++;
      $display("FAIL reset: pos=(%0d,%0d) vga=(%0d,%0d,%0d,%b) done=%b%b expected (76,100) zeros",
               car_x, car_y, vga_x, vga_y, vga_colour, vga_plot, done_car, done_clear);
    end
  endtask

  task automatic test_draw();
    tick();
    draw_car = 1;
    check_raster(0, -1, -1);
  endtask

  task automatic test_clear_priority();
    tick();
    clear = 1; draw_car = 1;
    check_raster(1, -1, -1);
    tick();
    vectors++;
    if (vga_plot !== 1'b0 || done_car !== 1'b0) begin
      errors++;
      $display("FAIL clear idle: plot=%b done_car=%b expected 0/0", vga_plot, done_car);
    end
  endtask

  task automatic test_move_clamp();
    for (int i = 0; i < 10; i++) pulse(0, 0, 1, 0);
    for (int i = 0; i < 20; i++) pulse(0, 0, 0, 1);
  endtask

  task automatic test_move_priority();
    pulse(0, 1, 1, 1);
    tick();
    draw_car = 1;
    check_raster(0, 10, -1);
  endtask

  task automatic test_random_moves();
    for (int n = 0; n < 90; n++) begin
      pulse($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) tick();
      if (n % 30 == 29) begin
        tick();
        if ($urandom_range(0, 1) == 1) begin
          draw_car = 1; check_raster(0, $urandom_range(0, 95), -1);
        end else begin
          clear = 1; check_raster(1, $urandom_range(0, 95), -1);
        end
      end
    end
  endtask

  task automatic test_reset_mid_raster();
    tick();
    draw_car = 1;
    check_raster(0, -1, 50);
    reset = 1;
    tick();
    reset = 0;
    mx = SX; my = SY;
    vectors++;
    if (vga_plot !== 1'b0 || car_x !== 8'(SX) || car_y !== 7'(SY) || done_car !== 1'b0) begin
      errors++;
      $display("FAIL reset mid raster: plot=%b pos=(%0d,%0d) done=%b expected 0 (76,100) 0",
               vga_plot, car_x, car_y, done_car);
    end
    check_raster(0, -1, -1);
  endtask

  task automatic test_reset_pos_and_top();
    for (int i = 0; i < 10; i++) pulse(0, 1, 0, 0);
    for (int i = 0; i < 7; i++)  pulse(0, 0, 1, 0);
    vectors++;
    if (car_x !== 8'd48 || car_y !== 7'd90) begin
      errors++;
      $display("FAIL reach 48,90: pos=(%0d,%0d) expected (48,90)", car_x, car_y);
    end
    pulse(1, 1, 1, 0);
    for (int i = 0; i < 103; i++) pulse(0, 1, 0, 0);
    vectors++;
    if (car_y !== 7'd0) begin
      errors++;
      $display("FAIL top clamp: y=%0d expected 0", car_y);
    end
  endtask

  initial begin
    test_reset();
    test_draw();
    test_clear_priority();
    test_move_clamp();
    test_move_priority();
    test_random_moves();
    test_reset_mid_raster();
    test_reset_pos_and_top();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
